// File: rtl/poly_addsub_stream_pkg.sv
// poly_addsub_stream_pkg: NewHope ring parameters and operation encodings
package poly_addsub_stream_pkg;
    localparam int NEWHOPE_Q = 12289;
    localparam int NEWHOPE_N = 1024;
    localparam int NEWHOPE_W = 16;
    typedef enum logic {MODE_SUB = 1'b0, MODE_ADD = 1'b1} mode_e;
endpackage

// File: rtl/modq_addsub_lane.sv
// modq_addsub_lane: one coefficient lane, S1 add/sub into W+1 bits, S2 conditional subtract of Q
module modq_addsub_lane
    import poly_addsub_stream_pkg::*;
#(
    parameter int W = NEWHOPE_W,
    parameter int Q = NEWHOPE_Q
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  mode_e        mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] red
);
    localparam logic [W:0] QE = (W+1)'(Q);
    logic [W:0] ae, be, t, t_nxt;
    assign ae = {1'b0, a};
    assign be = {1'b0, b};
    // Subtraction pre-adds Q on underflow so S2 only ever needs one conditional subtract
    assign t_nxt = (mode == MODE_ADD) ? ae + be : (a < b) ? ae + QE - be : ae - be;
    always_ff @(posedge clk) begin
        if (rst) begin
            t   <= '0;
            red <= '0;
        end else if (en) begin
            t   <= t_nxt;
            red <= (t >= QE) ? W'(t - QE) : t[W-1:0];
        end
    end
endmodule

// File: rtl/poly_addsub_stream.sv
// poly_addsub_stream: streaming two-stage coefficient-wise mod-Q add/sub of two polynomials
module poly_addsub_stream
    import poly_addsub_stream_pkg::*;
#(
    parameter int W     = NEWHOPE_W,
    parameter int Q     = NEWHOPE_Q,
    parameter int N     = NEWHOPE_N,
    parameter int LANES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] dia,
    input  logic [LANES*W-1:0] dib,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] red_out,
    output logic               out_last,
    output logic               done
);
    localparam int BEATS = N / LANES;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    logic [CW-1:0] in_cnt;
    logic mode_q, s1_valid, s1_last, adv, take, cur_mode, in_last;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;
    assign take     = in_valid && in_ready;
    assign in_last  = in_cnt == CW'(BEATS - 1);
    // The first beat of a polynomial uses the live mode; later beats use the latched one
    assign cur_mode = (in_cnt == '0) ? mode : mode_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt    <= '0;
            mode_q    <= 1'b0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (take) begin
                in_cnt <= in_last ? '0 : in_cnt + 1'b1;
                if (in_cnt == '0) mode_q <= mode;
            end
            if (adv) begin
                s1_valid  <= take;
                s1_last   <= take && in_last;
                out_valid <= s1_valid;
                out_last  <= s1_last;
            end
            done <= out_valid && out_ready && out_last;
        end
    end
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        modq_addsub_lane #(.W(W), .Q(Q)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .en   (adv),
            .mode (mode_e'(cur_mode)),
            .a    (dia[i*W +: W]),
            .b    (dib[i*W +: W]),
            .red  (red_out[i*W +: W])
        );
    end
endmodule

// File: tb/tb_poly_addsub_stream.sv
// tb_poly_addsub_stream: scoreboard bench for poly_addsub_stream with four lanes
module tb_poly_addsub_stream;
    localparam int W     = 16;
    localparam int Q     = 12289;
    localparam int N     = 1024;
    localparam int LANES = 4;
    localparam int LW    = LANES * W;
    localparam int BEATS = N / LANES;

    typedef struct {
        logic [LW-1:0] data;
        logic          last;
        int            idx;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [LW-1:0] dia = '0;
    logic [LW-1:0] dib = '0;
    logic in_ready, out_valid, out_last, done;
    logic [LW-1:0] red_out;

    sb_t sb[$];
    sb_t e;
    int n_cmp = 0, n_err = 0;
    int b_cnt = 0, stalls = 0, n_done = 0, cyc = 0, t0 = 0, t1 = 0;
    logic p_mode = 1'b0;
    bit rand_ready = 1'b0;
    bit done_exp = 1'b0;
    bit held_v = 1'b0;
    logic [LW-1:0] held = '0;

    poly_addsub_stream #(.W(W), .Q(Q), .N(N), .LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dia       (dia),
        .dib       (dib),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .red_out   (red_out),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] model(input logic md, input logic [LW-1:0] a, input logic [LW-1:0] b);
        logic [LW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            int x, y;
            x = int'(a[i*W +: W]);
            y = int'(b[i*W +: W]);
            r[i*W +: W] = W'(md ? (x + y) % Q : (x - y + Q) % Q);
        end
        return r;
    endfunction

    function automatic logic [LW-1:0] rep(input int x);
        return {LANES{W'(x)}};
    endfunction

    function automatic logic [LW-1:0] rand_vec();
        logic [LW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) r[i*W +: W] = W'($urandom_range(0, Q - 1));
        return r;
    endfunction

    // Monitor: picks out_ready, pops the scoreboard on each transfer, tracks done and stall stability
    always @(negedge clk) begin
        out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (rst) begin
            held_v   = 1'b0;
            done_exp = 1'b0;
        end else begin
            check("done", 64'(done), 64'(done_exp));
            if (done) n_done++;
            if (held_v && out_valid) check("stable", red_out, held);
            done_exp = 1'b0;
            if (out_valid && out_ready) begin
                held_v = 1'b0;
                if (sb.size() == 0) check("extra_beat", 64'd1, 64'd0);
                else begin
                    e = sb.pop_front();
                    check("data", red_out, e.data);
                    check("last", 64'(out_last), 64'(e.last));
                    done_exp = e.last;
                    if (e.idx == 0) t0 = cyc;
                    if (e.last) t1 = cyc;
                end
            end else begin
                held_v = out_valid;
                held   = red_out;
            end
        end
    end

    task automatic send_beat(input logic md, input logic [LW-1:0] a, input logic [LW-1:0] b,
                             input logic [LW-1:0] fx, input bit use_fx);
        int w;
        w = 0;
        @(negedge clk); #1;
        in_valid = 1'b1; mode = md; dia = a; dib = b;
        while (!in_ready && w < 1000) begin
            stalls++;
            w++;
            @(negedge clk); #1;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        if (b_cnt == 0) p_mode = md;
        sb.push_back('{use_fx ? fx : model(p_mode, a, b), b_cnt == BEATS - 1, b_cnt});
        b_cnt = (b_cnt == BEATS - 1) ? 0 : b_cnt + 1;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic send_poly(input logic md, input int toggle_at, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send_beat((i >= toggle_at) ? !md : md, rand_vec(), rand_vec(), '0, 1'b0);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); #3;
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        b_cnt = 0;
        @(negedge clk); #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_red_out", red_out, 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("init_in_ready", 64'(in_ready), 64'd0);
        check("init_out_valid", 64'(out_valid), 64'd0);
        check("init_out_last", 64'(out_last), 64'd0);
        check("init_done", 64'(done), 64'd0);
        check("init_red_out", red_out, 64'd0);
        rst = 1'b0;
        // Subtract corner cases, with a two-cycle latency check on the first beat
        send_beat(1'b0, rep(5), rep(10), rep(12284), 1'b1);
        @(negedge clk); #1;
        in_valid = 1'b0;
        check("latency_c1", 64'(out_valid), 64'd0);
        @(negedge clk); #1;
        check("latency_c2", 64'(out_valid), 64'd1);
        send_beat(1'b0, rep(10), rep(5), rep(5), 1'b1);
        send_beat(1'b0, rep(7), rep(7), rep(0), 1'b1);
        idle(1);
        drain();
        do_reset();
        // Addition corner cases, including the t == Q wrap
        send_beat(1'b1, rep(12288), rep(1), rep(0), 1'b1);
        send_beat(1'b1, rep(12288), rep(12288), rep(12287), 1'b1);
        send_beat(1'b1, rep(0), rep(0), rep(0), 1'b1);
        idle(1);
        drain();
        do_reset();
        // Full polynomial at full rate
        stalls = 0;
        send_poly(1'b0, BEATS, BEATS, 1'b0);
        idle(1);
        drain();
        check("stalls", 64'(stalls), 64'd0);
        check("throughput", 64'(t1 - t0), 64'(BEATS - 1));
        // Back-to-back polynomials with random backpressure and input gaps
        rand_ready = 1'b1;
        send_poly(1'b1, BEATS, BEATS, 1'b1);
        send_poly(1'b0, BEATS, BEATS, 1'b1);
        idle(1);
        drain();
        rand_ready = 1'b0;
        // Mode flips mid-polynomial must be ignored; next polynomial picks up add
        send_poly(1'b0, BEATS * 300 / 1024, BEATS, 1'b0);
        send_poly(1'b1, BEATS, BEATS, 1'b0);
        idle(1);
        drain();
        // Reset part-way through a polynomial, then a fresh one
        send_poly(1'b0, BEATS, BEATS * 500 / 1024, 1'b0);
        do_reset();
        send_poly(1'b1, BEATS, BEATS, 1'b0);
        idle(1);
        drain();
        check("done_count", 64'(n_done), 64'd6);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
